i2s_mic_rx: RTL
===============

Name: i2s_mic_rx

Overview:
- I2S master receiver for the MEMS microphone front end.
- Generates i2s_clk and i2s_ws, drives i2s_lr, and deserialises the selected channel of i2s_sd into DATA_SIZE-bit samples.
- Presents each sample on a valid/ready interface that feeds the sample reducer / byte FIFO path.
- Sits directly upstream of the FIFO write side inside the i2s_fpga wrapper.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- I2S_CLK_FREQ, 1_500_000: target bit clock in Hz. HALF_DIV = CLK_FREQ/(2*I2S_CLK_FREQ), floored, minimum 2 (16 at defaults).
- DATA_SIZE, 24: valid bits per sample, 1..31.
- SLOT_BITS, 32: bit clocks per channel slot. Frame length = 2*SLOT_BITS.
- CHANNEL, 0: channel captured. 0 = left (ws low), 1 = right (ws high). Also the value driven on i2s_lr.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run request; level sensitive.
- i2s_clk  out  1  I2S bit clock, generated from clk.
- i2s_ws  out  1  word select; 0 = left slot.
- i2s_lr  out  1  mic L/R strap; constant CHANNEL.
- i2s_sd  in  1  serial data from mic; asynchronous to clk.
- sample_data  out  DATA_SIZE  captured sample, MSB-first order preserved, two's complement.
- sample_valid  out  1  sample_data holds an unaccepted sample.
- sample_ready  in  1  downstream accepts when valid && ready.
- overrun  out  1  sticky: a sample was dropped because the holding register was still full.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; i2s_clk=0, i2s_ws=0, sample_data=0, sample_valid=0, overrun=0, busy=0; divider, bit counter and shift register cleared. i2s_lr=CHANNEL always.
- Reset mid-frame aborts immediately. The partial sample is discarded and no valid is raised.
- i2s_sd passes through a 2-flop synchroniser; only the synchronised bit is used.
- Divider:
  - div_cnt counts 0..HALF_DIV-1 while state != IDLE.
  - At HALF_DIV-1, i2s_clk toggles and div_cnt wraps to 0.
  - rise_evt / fall_evt are the single clk cycles in which i2s_clk goes 0->1 / 1->0.
- Bit counter:
  - bit_cnt 0..2*SLOT_BITS-1 advances on fall_evt and wraps to 0.
  - i2s_ws updates on fall_evt to (next bit_cnt >= SLOT_BITS).
- Capture (standard I2S one-bit delay):
  - Slot-relative index s = bit_cnt mod SLOT_BITS. The selected slot is the one where i2s_ws == CHANNEL.
  - On rise_evt in the selected slot with 1 <= s <= DATA_SIZE, shift the synchronised sd into the LSB.
  - Bits at s=0 and s>DATA_SIZE are ignored (tri-stated by the mic).
  - On the rise_evt that captures s=DATA_SIZE, a sample is complete. The next clk cycle loads the holding register.
- States:
  - IDLE: clock stopped low, ws=0. enable=1 -> SYNC.
  - SYNC: clock runs from bit_cnt=0, ws=0, but captures are suppressed until the first fall_evt where bit_cnt wraps 2*SLOT_BITS-1 -> 0, then -> RUN. This discards one frame of mic settling.
  - RUN: capture active. enable=0 -> DRAIN.
  - DRAIN: continue to end of frame (wrap to bit_cnt=0). Then stop the clock with i2s_clk=0 and ws=0 -> IDLE. A sample that completes inside DRAIN is still delivered. enable=1 during DRAIN -> RUN with no gap.
- Handshake (one-entry holding register):
  - sample_valid rises the cycle after completion.
  - sample_valid and sample_data stay stable until valid && sample_ready; valid falls the next cycle.
  - If a new sample completes while valid=1 and ready=0, the new sample is dropped, the old one is kept, and overrun is set.
  - If completion coincides with acceptance, the register reloads and valid stays 1; this is not an overrun.
  - overrun clears only on rst.
  - Valid persists through IDLE until accepted.
- Timing at defaults: i2s_clk period 32 clk, frame 2048 clk, sample rate 24414 Hz.

Decomposition:
- Shared package i2s_pkg holds:
  - typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} i2s_rx_state_t;
  - localparam function computing HALF_DIV with the minimum-2 clamp;
  - channel constants CH_LEFT=0, CH_RIGHT=1.
- One natural sub-module: i2s_clk_gen (divider, rise/fall strobes, bit counter, ws).
- Capture, FSM and holding register stay in i2s_mic_rx.

Test Plan:
- Reset, then enable=1 -> i2s_clk period 32 clk; ws low for 1024 clk, high for 1024 clk; no valid during the first (SYNC) frame.
- CHANNEL=0; model drives left data 24'hA5C3F1 MSB-first from slot bit 1, right data 24'h123456; ready=1 -> sample_valid=1 with sample_data=24'hA5C3F1 one cycle after the 24th left rise_evt; right data never appears.
- CHANNEL=1, same stimulus -> sample_data=24'h123456; i2s_lr=1.
- ready=0 for two frames -> first sample held stable, second dropped, overrun=1. Then ready=1 -> first sample accepted, valid falls, overrun stays 1.
- enable=0 at bit_cnt=40 in RUN -> frame completes, then i2s_clk=0, ws=0, busy=0. Re-enable re-enters SYNC with one discarded frame.
- rst=1 at left slot bit 12 -> all outputs at reset values the next cycle, no partial sample emitted; i2s_lr remains CHANNEL.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_pkg
//  Purpose  : Shared types and helpers for the I2S microphone receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } i2s_rx_state_t;

  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;

  // Half bit-clock period in system clocks; never below 2 so the strobes stay distinct.
  function automatic int calc_half_div(input int clk_freq, input int sclk_freq);
    int div;
    div = clk_freq / (2 * sclk_freq);
    return (div < 2) ? 2 : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_clk_gen
//  Purpose  : Bit-clock divider, edge strobes, frame bit counter and word select.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_clk_gen #(
  parameter int HALF_DIV  = 16,
  parameter int SLOT_BITS = 32,
  parameter int BIT_W     = $clog2(2 * SLOT_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             i2s_clk,
  output logic             i2s_ws,
  output logic             rise_evt,
  output logic             wrap_evt,
  output logic [BIT_W-1:0] bit_cnt
);

  localparam int               c_div_w      = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] c_frame_last = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] c_slot       = BIT_W'(SLOT_BITS);

  logic [c_div_w-1:0] r_div_cnt;
  logic               r_sclk;
  logic               r_ws;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [BIT_W-1:0]   w_bit_next;
  logic               w_div_last;
  logic               w_fall;

  assign w_div_last = run && (r_div_cnt == c_div_last);
  assign w_fall     = w_div_last && r_sclk;
  assign w_bit_next = (r_bit_cnt == c_frame_last) ? '0 : r_bit_cnt + BIT_W'(1);

  // Stopping the divider parks everything at the frame origin, ready for a clean restart.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
      r_ws      <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      r_div_cnt <= w_div_last ? '0 : r_div_cnt + c_div_w'(1);
      if (w_div_last) r_sclk <= ~r_sclk;
      if (w_fall) begin
        r_bit_cnt <= w_bit_next;
        r_ws      <= (w_bit_next >= c_slot);
      end
    end
  end

  assign i2s_clk  = r_sclk;
  assign i2s_ws   = r_ws;
  assign bit_cnt  = r_bit_cnt;
  assign rise_evt = w_div_last && !r_sclk;
  assign wrap_evt = w_fall && (r_bit_cnt == c_frame_last);

endmodule
`default_nettype wire

// File: rtl/i2s_mic_rx.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_mic_rx
//  Purpose  : I2S master receiver; captures one channel into a valid/ready sample.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int I2S_CLK_FREQ = 1_500_000,
  parameter int DATA_SIZE    = 24,
  parameter int SLOT_BITS    = 32,
  parameter int CHANNEL      = CH_LEFT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 i2s_clk,
  output logic                 i2s_ws,
  output logic                 i2s_lr,
  input  logic                 i2s_sd,
  output logic [DATA_SIZE-1:0] sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int                 c_half_div  = calc_half_div(CLK_FREQ, I2S_CLK_FREQ);
  localparam int                 c_bit_w     = $clog2(2 * SLOT_BITS);
  localparam logic               c_channel   = (CHANNEL == CH_RIGHT);
  localparam logic [c_bit_w-1:0] c_slot      = c_bit_w'(SLOT_BITS);
  localparam logic [31:0]        c_data_last = 32'(DATA_SIZE);

  i2s_rx_state_t        r_state;
  i2s_rx_state_t        w_state_next;
  logic                 r_sd_meta;
  logic                 r_sd_sync;
  logic [DATA_SIZE-1:0] r_shift;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_done;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 w_run;
  logic                 w_rise;
  logic                 w_wrap;
  logic                 w_sclk;
  logic                 w_ws;
  logic [c_bit_w-1:0]   w_bit_cnt;
  logic [31:0]          w_slot_idx;
  logic                 w_capture;

  assign w_run = (r_state != IDLE);

  i2s_clk_gen #(
    .HALF_DIV  (c_half_div),
    .SLOT_BITS (SLOT_BITS),
    .BIT_W     (c_bit_w)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .run      (w_run),
    .i2s_clk  (w_sclk),
    .i2s_ws   (w_ws),
    .rise_evt (w_rise),
    .wrap_evt (w_wrap),
    .bit_cnt  (w_bit_cnt)
  );

  // ws tracks bit_cnt >= SLOT_BITS, so it also tells which half to subtract.
  assign w_slot_idx = 32'(w_ws ? (w_bit_cnt - c_slot) : w_bit_cnt);
  assign w_capture  = w_rise && (r_state == RUN || r_state == DRAIN) &&
                      (w_ws == c_channel) && (w_slot_idx != 32'd0) &&
                      (w_slot_idx <= c_data_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_next = SYNC;
      SYNC:    if (w_wrap) w_state_next = enable ? RUN : IDLE;
      RUN:     if (!enable) w_state_next = DRAIN;
      DRAIN: begin
        if (enable)      w_state_next = RUN;
        else if (w_wrap) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sd_meta <= 1'b0;
      r_sd_sync <= 1'b0;
      r_shift   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_sd_meta <= i2s_sd;
      r_sd_sync <= r_sd_meta;
      if (w_capture) r_shift <= DATA_SIZE'({r_shift, r_sd_sync});
      r_done <= w_capture && (w_slot_idx == c_data_last);
    end
  end

  // One-entry holding register: a completion with the slot still occupied is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_done) begin
      if (!r_valid || sample_ready) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && sample_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign i2s_clk      = w_sclk;
  assign i2s_ws       = w_ws;
  assign i2s_lr       = c_channel;
  assign sample_data  = r_data;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
  assign busy         = w_run;

endmodule
`default_nettype wire
